// File: rtl/rs_issue_scheduler_pkg.sv
// Shared definitions for the arithmetic reservation-station issue scheduler.
//   RS_ENTRIES / RS_IDX_W : default slot count and index width
//   onehot_to_idx         : encode a one-hot slot vector to its index
//   lowest_set            : priority encoder (lowest set bit), shared by alloc and RS
package rs_issue_scheduler_pkg;

  localparam int unsigned RS_ENTRIES     = 8;
  localparam int unsigned RS_IDX_W       = 3;
  localparam int unsigned RS_MAX_ENTRIES = 16;

  typedef logic [RS_MAX_ENTRIES-1:0] rs_vec_t;
  typedef logic [3:0]                rs_max_idx_t;

  // Where this cycle's oldest (A) / second-oldest (B) picks are sent.
  typedef enum logic [1:0] {
    ROUTE_NONE,
    ROUTE_A_ALU1,
    ROUTE_A_ALU2,
    ROUTE_DUAL
  } route_e;

  function automatic rs_max_idx_t onehot_to_idx(input rs_vec_t oh);
    rs_max_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < RS_MAX_ENTRIES; i++) begin
      if (oh[i]) idx = idx | rs_max_idx_t'(i);
    end
    return idx;
  endfunction

  // Returns 0 when no bit is set.
  function automatic rs_max_idx_t lowest_set(input rs_vec_t vec);
    rs_max_idx_t idx;
    logic        found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RS_MAX_ENTRIES; i++) begin
      if (vec[i] && !found) begin
        idx   = rs_max_idx_t'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_issue_scheduler_oldest_select.sv
// Combinational oldest-candidate selector.
//   cand   : candidate slots
//   older  : age matrix, older[j][i]=1 => slot j allocated before slot i
//   onehot : the single candidate no other candidate is older than
//   any    : at least one candidate present
module rs_issue_scheduler_oldest_select
  import rs_issue_scheduler_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = RS_ENTRIES
) (
  input  logic [NUM_ENTRIES-1:0]                  cand,
  input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older,
  output logic [NUM_ENTRIES-1:0]                  onehot,
  output logic                                    any
);

  logic [NUM_ENTRIES-1:0] beaten;

  always_comb begin
    beaten = '0;
    onehot = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && cand[j] && older[j][i]) beaten[i] = 1'b1;
      end
      onehot[i] = cand[i] & ~beaten[i];
    end
    any = |onehot;
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// RS slot allocator and dual-issue selector.
//   flush                 : synchronous clear of slots and grants (beats alloc/issue)
//   alloc_req/idx/ok,full : lowest free slot handed to rename when not full
//   entry_ready           : per-slot operands-available from RS
//   alu1_en/alu2_en       : ALU acceptance for next cycle
//   issue{1,2}_valid/idx  : registered grants of the two oldest ready slots
//   valid_vec             : slot occupancy
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = RS_ENTRIES,
  parameter int unsigned IDX_W       = RS_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc_req,
  output logic [IDX_W-1:0]       alloc_idx,
  output logic                   alloc_ok,
  output logic                   full,
  input  logic [NUM_ENTRIES-1:0] entry_ready,
  input  logic                   alu1_en,
  input  logic                   alu2_en,
  output logic                   issue1_valid,
  output logic [IDX_W-1:0]       issue1_idx,
  output logic                   issue2_valid,
  output logic [IDX_W-1:0]       issue2_idx,
  output logic [NUM_ENTRIES-1:0] valid_vec
);

  typedef logic [NUM_ENTRIES-1:0] vec_t;

  vec_t                                  valid_q, valid_d;
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_q, older_d;
  logic                                  issue1_valid_q, issue1_valid_d;
  logic                                  issue2_valid_q, issue2_valid_d;
  logic [IDX_W-1:0]                      issue1_idx_q, issue1_idx_d;
  logic [IDX_W-1:0]                      issue2_idx_q, issue2_idx_d;

  vec_t             free_vec, alloc_oh, cand, cand_b, pick_a, pick_b, issue_mask;
  logic             any_a, any_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  route_e           route;

  assign cand   = valid_q & entry_ready;
  assign cand_b = cand & ~pick_a;

  rs_issue_scheduler_oldest_select #(.NUM_ENTRIES(NUM_ENTRIES)) u_sel_a (
    .cand   (cand),
    .older  (older_q),
    .onehot (pick_a),
    .any    (any_a)
  );

  rs_issue_scheduler_oldest_select #(.NUM_ENTRIES(NUM_ENTRIES)) u_sel_b (
    .cand   (cand_b),
    .older  (older_q),
    .onehot (pick_b),
    .any    (any_b)
  );

  always_comb begin
    free_vec  = ~valid_q;
    full      = &valid_q;
    alloc_idx = IDX_W'(lowest_set(rs_vec_t'(free_vec)));
    alloc_ok  = alloc_req & ~full;
    alloc_oh  = alloc_ok ? (vec_t'(1) << alloc_idx) : '0;
    idx_a     = IDX_W'(onehot_to_idx(rs_vec_t'(pick_a)));
    idx_b     = IDX_W'(onehot_to_idx(rs_vec_t'(pick_b)));

    if (!any_a)                 route = ROUTE_NONE;
    else if (alu1_en && alu2_en) route = ROUTE_DUAL;
    else if (alu1_en)           route = ROUTE_A_ALU1;
    else if (alu2_en)           route = ROUTE_A_ALU2;
    else                        route = ROUTE_NONE;

    issue1_valid_d = 1'b0;
    issue1_idx_d   = '0;
    issue2_valid_d = 1'b0;
    issue2_idx_d   = '0;
    issue_mask     = '0;
    case (route)
      ROUTE_DUAL: begin
        issue1_valid_d = 1'b1;
        issue1_idx_d   = idx_a;
        issue2_valid_d = any_b;
        issue2_idx_d   = any_b ? idx_b : '0;
        issue_mask     = pick_a | pick_b;
      end
      ROUTE_A_ALU1: begin
        issue1_valid_d = 1'b1;
        issue1_idx_d   = idx_a;
        issue_mask     = pick_a;
      end
      ROUTE_A_ALU2: begin
        issue2_valid_d = 1'b1;
        issue2_idx_d   = idx_a;
        issue_mask     = pick_a;
      end
      default: ;
    endcase

    // alloc_idx is always a pre-edge free slot, so it never collides with issue_mask.
    valid_d = (valid_q & ~issue_mask) | alloc_oh;

    // New slot is younger than every pre-edge valid slot, including ones issuing
    // this cycle; the column write also clears the diagonal since the slot was free.
    older_d = older_q;
    if (alloc_ok) begin
      older_d[alloc_idx] = '0;
      for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
        older_d[j][alloc_idx] = valid_q[j];
      end
    end

    if (flush) begin
      valid_d        = '0;
      older_d        = '0;
      issue1_valid_d = 1'b0;
      issue1_idx_d   = '0;
      issue2_valid_d = 1'b0;
      issue2_idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= '0;
      older_q        <= '0;
      issue1_valid_q <= 1'b0;
      issue1_idx_q   <= '0;
      issue2_valid_q <= 1'b0;
      issue2_idx_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      older_q        <= older_d;
      issue1_valid_q <= issue1_valid_d;
      issue1_idx_q   <= issue1_idx_d;
      issue2_valid_q <= issue2_valid_d;
      issue2_idx_q   <= issue2_idx_d;
    end
  end

  assign valid_vec    = valid_q;
  assign issue1_valid = issue1_valid_q;
  assign issue1_idx   = issue1_idx_q;
  assign issue2_valid = issue2_valid_q;
  assign issue2_idx   = issue2_idx_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
module tb_rs_issue_scheduler;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, flush, alloc_req, alu1_en, alu2_en;
  logic [N-1:0] entry_ready;
  logic [2:0]   alloc_idx, issue1_idx, issue2_idx;
  logic         alloc_ok, full, issue1_valid, issue2_valid;
  logic [N-1:0] valid_vec;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: occupancy plus an allocation timestamp per slot.
  bit              m_valid[N];
  longint unsigned m_ts[N];
  longint unsigned m_stamp = 0;
  bit              m_i1v, m_i2v;
  int              m_i1, m_i2;

  rs_issue_scheduler #(.NUM_ENTRIES(8), .IDX_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc_req    (alloc_req),
    .alloc_idx    (alloc_idx),
    .alloc_ok     (alloc_ok),
    .full         (full),
    .entry_ready  (entry_ready),
    .alu1_en      (alu1_en),
    .alu2_en      (alu2_en),
    .issue1_valid (issue1_valid),
    .issue1_idx   (issue1_idx),
    .issue2_valid (issue2_valid),
    .issue2_idx   (issue2_idx),
    .valid_vec    (valid_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_i1v = 1'b0; m_i2v = 1'b0; m_i1 = 0; m_i2 = 0;
  endtask

  // One clock: model consumes the inputs present at the edge; returns 1 time unit after.
  task automatic cycle();
    int k, a, b;
    @(posedge clk);
    k = m_free();
    if (flush) begin
      model_clear();
    end else begin
      a = -1; b = -1;
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && entry_ready[i]) begin
          if (a < 0 || m_ts[i] < m_ts[a]) begin b = a; a = i; end
          else if (b < 0 || m_ts[i] < m_ts[b]) b = i;
        end
      end
      m_i1v = 1'b0; m_i2v = 1'b0; m_i1 = 0; m_i2 = 0;
      if (a >= 0) begin
        if (alu1_en) begin
          m_i1v = 1'b1; m_i1 = a;
          if (alu2_en && b >= 0) begin m_i2v = 1'b1; m_i2 = b; end
        end else if (alu2_en) begin
          m_i2v = 1'b1; m_i2 = a;
        end
      end
      if (m_i1v) m_valid[m_i1] = 1'b0;
      if (m_i2v) m_valid[m_i2] = 1'b0;
      if (alloc_req && k >= 0) begin
        m_valid[k] = 1'b1;
        m_ts[k]    = m_stamp;
        m_stamp++;
      end
    end
    #1;
  endtask

  task automatic flush_all();
    flush = 1'b1; alloc_req = 1'b0; entry_ready = '0;
    cycle();
    flush = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    alloc_req = 1'b1;
    repeat (n) cycle();
    alloc_req = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (valid_vec !== 8'h00) begin n_bad++; $display("FAIL reset_valid got %h exp 00", valid_vec); end
    n_cmp++; if (issue1_valid !== 1'b0 || issue2_valid !== 1'b0) begin n_bad++; $display("FAIL reset_issue got %b%b exp 00", issue1_valid, issue2_valid); end
    n_cmp++; if (alloc_idx !== 3'd0 || full !== 1'b0) begin n_bad++; $display("FAIL reset_alloc idx %0d full %b exp 0 0", alloc_idx, full); end
    alloc_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (alloc_idx !== 3'(i) || alloc_ok !== 1'b1) begin n_bad++; $display("FAIL fill_alloc idx %0d ok %b exp %0d 1", alloc_idx, alloc_ok, i); end
      cycle();
    end
    alloc_req = 1'b0;
    n_cmp++; if (valid_vec !== 8'h1F) begin n_bad++; $display("FAIL fill5_valid got %h exp 1f", valid_vec); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (valid_vec !== 8'h00) begin n_bad++; $display("FAIL midrun_reset_valid got %h exp 00", valid_vec); end
    n_cmp++; if (issue1_valid !== 1'b0 || issue2_valid !== 1'b0 || issue1_idx !== 3'd0 || issue2_idx !== 3'd0) begin n_bad++; $display("FAIL midrun_reset_issue got %b%b %0d %0d exp 00 0 0", issue1_valid, issue2_valid, issue1_idx, issue2_idx); end
    n_cmp++; if (alloc_idx !== 3'd0) begin n_bad++; $display("FAIL midrun_reset_alloc got %0d exp 0", alloc_idx); end
  endtask

  task automatic test_single_ready();
    flush_all();
    alloc_n(3);
    alu1_en = 1'b1; alu2_en = 1'b1; entry_ready = 8'b0000_0100;
    cycle();
    entry_ready = '0;
    n_cmp++; if (issue1_valid !== 1'b1 || issue1_idx !== 3'd2) begin n_bad++; $display("FAIL single_issue1 got %b/%0d exp 1/2", issue1_valid, issue1_idx); end
    n_cmp++; if (issue2_valid !== 1'b0) begin n_bad++; $display("FAIL single_issue2 got %b exp 0", issue2_valid); end
    n_cmp++; if (valid_vec !== 8'b0000_0011) begin n_bad++; $display("FAIL single_valid got %b exp 00000011", valid_vec); end
  endtask

  task automatic test_age_order();
    flush_all();
    alloc_n(4);
    entry_ready = 8'b0000_0001;
    cycle();
    entry_ready = '0;
    #1;
    n_cmp++; if (issue1_valid !== 1'b1 || issue1_idx !== 3'd0) begin n_bad++; $display("FAIL age_free0 got %b/%0d exp 1/0", issue1_valid, issue1_idx); end
    n_cmp++; if (alloc_idx !== 3'd0 || valid_vec !== 8'h0E) begin n_bad++; $display("FAIL age_realloc idx %0d valid %h exp 0 0e", alloc_idx, valid_vec); end
    alloc_n(1);
    entry_ready = 8'h0F;
    cycle();
    n_cmp++; if (issue1_idx !== 3'd1 || issue2_idx !== 3'd2 || !issue1_valid || !issue2_valid) begin n_bad++; $display("FAIL age_first got %0d,%0d exp 1,2", issue1_idx, issue2_idx); end
    cycle();
    n_cmp++; if (issue1_idx !== 3'd3 || issue2_idx !== 3'd0 || !issue1_valid || !issue2_valid) begin n_bad++; $display("FAIL age_second got %0d,%0d exp 3,0", issue1_idx, issue2_idx); end
    entry_ready = '0;
    cycle();
    n_cmp++; if (issue1_valid !== 1'b0 || issue2_valid !== 1'b0) begin n_bad++; $display("FAIL age_idle got %b%b exp 00", issue1_valid, issue2_valid); end
  endtask

  task automatic test_alu2_only();
    flush_all();
    alloc_n(6);
    alu1_en = 1'b0; alu2_en = 1'b1; entry_ready = 8'b0011_0000;
    cycle();
    n_cmp++; if (issue1_valid !== 1'b0 || issue2_valid !== 1'b1 || issue2_idx !== 3'd4) begin n_bad++; $display("FAIL alu2_first got %b %b/%0d exp 0 1/4", issue1_valid, issue2_valid, issue2_idx); end
    cycle();
    n_cmp++; if (issue1_valid !== 1'b0 || issue2_valid !== 1'b1 || issue2_idx !== 3'd5) begin n_bad++; $display("FAIL alu2_second got %b %b/%0d exp 0 1/5", issue1_valid, issue2_valid, issue2_idx); end
    entry_ready = '0; alu1_en = 1'b1;
  endtask

  task automatic test_full();
    flush_all();
    alloc_n(8);
    alloc_req = 1'b1;
    #1;
    n_cmp++; if (full !== 1'b1 || alloc_ok !== 1'b0 || valid_vec !== 8'hFF) begin n_bad++; $display("FAIL full_state full %b ok %b valid %h exp 1 0 ff", full, alloc_ok, valid_vec); end
    cycle();
    n_cmp++; if (valid_vec !== 8'hFF) begin n_bad++; $display("FAIL full_ignored got %h exp ff", valid_vec); end
    entry_ready = 8'b0100_1000;
    cycle();
    entry_ready = '0;
    #1;
    n_cmp++; if (issue1_idx !== 3'd3 || issue2_idx !== 3'd6 || !issue1_valid || !issue2_valid) begin n_bad++; $display("FAIL full_issue got %0d,%0d exp 3,6", issue1_idx, issue2_idx); end
    n_cmp++; if (full !== 1'b0 || alloc_idx !== 3'd3 || alloc_ok !== 1'b1) begin n_bad++; $display("FAIL full_freed full %b idx %0d ok %b exp 0 3 1", full, alloc_idx, alloc_ok); end
    alloc_req = 1'b0;
  endtask

  task automatic test_flush();
    flush_all();
    alloc_n(3);
    alloc_req = 1'b1; entry_ready = 8'hFF; flush = 1'b1;
    cycle();
    flush = 1'b0; alloc_req = 1'b0; entry_ready = '0;
    n_cmp++; if (valid_vec !== 8'h00) begin n_bad++; $display("FAIL flush_valid got %h exp 00", valid_vec); end
    n_cmp++; if (issue1_valid !== 1'b0 || issue2_valid !== 1'b0 || issue1_idx !== 3'd0 || issue2_idx !== 3'd0) begin n_bad++; $display("FAIL flush_issue got %b%b %0d %0d exp 00 0 0", issue1_valid, issue2_valid, issue1_idx, issue2_idx); end
    cycle();
    n_cmp++; if (valid_vec !== 8'h00 || issue1_valid !== 1'b0) begin n_bad++; $display("FAIL flush_after valid %h iv %b exp 00 0", valid_vec, issue1_valid); end
  endtask

  task automatic test_random();
    int fk;
    for (int c = 0; c < 600; c++) begin
      alloc_req   = ($urandom_range(0, 3) != 0);
      entry_ready = N'($urandom & $urandom);
      alu1_en     = ($urandom_range(0, 3) != 0);
      alu2_en     = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 49) == 0);
      #1;
      fk = m_free();
      n_cmp++; if (valid_vec !== m_vec()) begin n_bad++; $display("FAIL rnd_valid c%0d got %h exp %h", c, valid_vec, m_vec()); end
      n_cmp++; if (full !== (fk < 0) || alloc_ok !== (alloc_req && fk >= 0)) begin n_bad++; $display("FAIL rnd_full c%0d full %b ok %b exp %b %b", c, full, alloc_ok, fk < 0, alloc_req && fk >= 0); end
      if (fk >= 0) begin
        n_cmp++; if (alloc_idx !== 3'(fk)) begin n_bad++; $display("FAIL rnd_alloc_idx c%0d got %0d exp %0d", c, alloc_idx, fk); end
      end
      cycle();
      n_cmp++; if (issue1_valid !== m_i1v || issue2_valid !== m_i2v) begin n_bad++; $display("FAIL rnd_issue_valid c%0d got %b%b exp %b%b", c, issue1_valid, issue2_valid, m_i1v, m_i2v); end
      if (m_i1v) begin
        n_cmp++; if (issue1_idx !== 3'(m_i1)) begin n_bad++; $display("FAIL rnd_issue1_idx c%0d got %0d exp %0d", c, issue1_idx, m_i1); end
      end
      if (m_i2v) begin
        n_cmp++; if (issue2_idx !== 3'(m_i2)) begin n_bad++; $display("FAIL rnd_issue2_idx c%0d got %0d exp %0d", c, issue2_idx, m_i2); end
      end
    end
    flush = 1'b0; alloc_req = 1'b0; entry_ready = '0; alu1_en = 1'b1; alu2_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_req = 1'b0; entry_ready = '0;
    alu1_en = 1'b1; alu2_en = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    test_single_ready();
    test_age_order();
    test_alu2_only();
    test_full();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
